// File: rtl/rtc_cfg_pkg.sv
// Shared codes, state encoding and sizing helpers
// for the RTC field chip-select selector.
package rtc_cfg_pkg;

  localparam logic [2:0] CONF_NONE  = 3'b000;
  localparam logic [2:0] CONF_HORA  = 3'b001;
  localparam logic [2:0] CONF_FECHA = 3'b010;
  localparam logic [2:0] CONF_TIMER = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    ED_HORA,
    ED_FECHA,
    ED_TIMER
  } estado_t;

  localparam int N_HORA_DEF  = 3;
  localparam int N_FECHA_DEF = 4;
  localparam int N_TIMER_DEF = 3;

  function automatic int cw_de(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  localparam int CW_DEF = cw_de(N_HORA_DEF, N_FECHA_DEF, N_TIMER_DEF);

  function automatic estado_t est_de(input logic [2:0] c);
    estado_t e;
    case (c)
      CONF_HORA:  e = ED_HORA;
      CONF_FECHA: e = ED_FECHA;
      CONF_TIMER: e = ED_TIMER;
      default:    e = IDLE;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/contador_timeout.sv
// Idle-cycle counter for edit modes; expira flags
// the last counted cycle before automatic exit.
module contador_timeout #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expira
);

  localparam int W = $clog2(TIMEOUT_CYC);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expira = en && (cnt_q == W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/selector_cs_campos_rtc.sv
// Registered RTC chip-select decoder with an
// edit cursor per field group and idle timeout.
module selector_cs_campos_rtc
  import rtc_cfg_pkg::*;
#(
  parameter  int N_HORA      = N_HORA_DEF,
  parameter  int N_FECHA     = N_FECHA_DEF,
  parameter  int N_TIMER     = N_TIMER_DEF,
  parameter  int TIMEOUT_CYC = 1000,
  localparam int CW = cw_de(N_HORA, N_FECHA, N_TIMER)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         funcion_conf,
  input  logic               flag_mostrar_count,
  input  logic               btn_izq,
  input  logic               btn_der,
  output logic [N_HORA-1:0]  cs_hora,
  output logic [N_FECHA-1:0] cs_fecha,
  output logic [N_TIMER-1:0] cs_timer,
  output logic [CW-1:0]      cursor,
  output logic               editando,
  output logic               fin_edicion
);

  estado_t      state_q, state_d;
  logic [CW-1:0] cursor_d;
  logic [2:0]   conf_prev;
  logic         legal, cambio;
  logic         btn_any, clr, en, expira;
  logic [CW-1:0] lim;

  logic [N_HORA-1:0]  cs_hora_d;
  logic [N_FECHA-1:0] cs_fecha_d;
  logic [N_TIMER-1:0] cs_timer_d;
  logic               editando_d, fin_d;

  assign btn_any = btn_izq | btn_der;
  assign en      = (state_q != IDLE) && !btn_any;
  assign clr     = (state_q == IDLE) || (state_d != state_q) || btn_any;

  contador_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .en    (en),
    .expira(expira)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cursor      <= '0;
      conf_prev   <= CONF_NONE;
      cs_hora     <= '0;
      cs_fecha    <= '0;
      cs_timer    <= '0;
      editando    <= 1'b0;
      fin_edicion <= 1'b0;
    end else begin
      state_q     <= state_d;
      cursor      <= cursor_d;
      conf_prev   <= funcion_conf;
      cs_hora     <= cs_hora_d;
      cs_fecha    <= cs_fecha_d;
      cs_timer    <= cs_timer_d;
      editando    <= editando_d;
      fin_edicion <= fin_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cursor_d = cursor;
    legal    = (funcion_conf == CONF_HORA)
            || (funcion_conf == CONF_FECHA)
            || (funcion_conf == CONF_TIMER);
    cambio   = funcion_conf != conf_prev;
    unique case (state_q)
      ED_HORA:  lim = CW'(N_HORA - 1);
      ED_FECHA: lim = CW'(N_FECHA - 1);
      ED_TIMER: lim = CW'(N_TIMER - 1);
      default:  lim = '0;
    endcase
    unique case (state_q)
      IDLE: begin
        cursor_d = '0;
        if (cambio && legal) state_d = est_de(funcion_conf);
      end
      ED_HORA, ED_FECHA, ED_TIMER: begin
        // mode change outranks cursor movement
        if (!legal || cambio || expira) begin
          state_d  = est_de(funcion_conf);
          if (expira && !cambio) state_d = IDLE;
          cursor_d = '0;
        end else begin
          unique case (1'b1)
            (btn_der && !btn_izq):
              cursor_d = (cursor == lim) ? '0 : cursor + 1'b1;
            (btn_izq && !btn_der):
              cursor_d = (cursor == '0) ? lim : cursor - 1'b1;
            default: cursor_d = cursor;
          endcase
        end
      end
      default: begin
        state_d  = IDLE;
        cursor_d = '0;
      end
    endcase

    cs_hora_d  = '0;
    cs_fecha_d = '0;
    cs_timer_d = flag_mostrar_count ? '1 : '0;
    unique case (state_d)
      ED_HORA:  cs_hora_d  = N_HORA'(1) << cursor_d;
      ED_FECHA: cs_fecha_d = N_FECHA'(1) << cursor_d;
      ED_TIMER: cs_timer_d = N_TIMER'(1) << cursor_d;
      default:  ;
    endcase
    editando_d = state_d != IDLE;
    fin_d      = (state_q != IDLE) && (state_d == IDLE);
  end

endmodule

// File: tb/tb_selector_cs_campos_rtc.sv
// Directed scoreboard bench for the RTC chip-select
// selector, built with an 8-cycle edit timeout.
module tb_selector_cs_campos_rtc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] funcion_conf;
  logic       flag_mostrar_count;
  logic       btn_izq, btn_der;
  logic [2:0] cs_hora;
  logic [3:0] cs_fecha;
  logic [2:0] cs_timer;
  logic [1:0] cursor;
  logic       editando, fin_edicion;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [2:0] h;
    logic [3:0] f;
    logic [2:0] t;
    logic [1:0] c;
    logic       ed;
    logic       fin;
  } exp_t;

  exp_t sb[$];

  selector_cs_campos_rtc #(
    .N_HORA(3), .N_FECHA(4), .N_TIMER(3), .TIMEOUT_CYC(8)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .funcion_conf      (funcion_conf),
    .flag_mostrar_count(flag_mostrar_count),
    .btn_izq           (btn_izq),
    .btn_der           (btn_der),
    .cs_hora           (cs_hora),
    .cs_fecha          (cs_fecha),
    .cs_timer          (cs_timer),
    .cursor            (cursor),
    .editando          (editando),
    .fin_edicion       (fin_edicion)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [2:0] h, input logic [3:0] f,
                              input logic [2:0] t, input logic [1:0] c,
                              input logic ed, input logic fin);
    exp_t e;
    e.h = h; e.f = f; e.t = t; e.c = c; e.ed = ed; e.fin = fin;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare(input string tag);
    exp_t e;
    e = sb.pop_front();
    chk({tag, ".cs_hora"},  8'(cs_hora),     8'(e.h));
    chk({tag, ".cs_fecha"}, 8'(cs_fecha),    8'(e.f));
    chk({tag, ".cs_timer"}, 8'(cs_timer),    8'(e.t));
    chk({tag, ".cursor"},   8'(cursor),      8'(e.c));
    chk({tag, ".editando"}, 8'(editando),    8'(e.ed));
    chk({tag, ".fin"},      8'(fin_edicion), 8'(e.fin));
  endtask

  task automatic step(input string tag, input logic [2:0] c,
                      input logic f, input logic i, input logic d,
                      input exp_t e);
    funcion_conf       = c;
    flag_mostrar_count = f;
    btn_izq            = i;
    btn_der            = d;
    sb.push_back(e);
    @(posedge clk);
    #1;
    btn_izq = 1'b0;
    btn_der = 1'b0;
    compare(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    funcion_conf = 3'b000;
    flag_mostrar_count = 1'b0;
    btn_izq = 1'b0;
    btn_der = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(mk(0, 0, 0, 0, 0, 0));
    compare("reset");
    rst_n = 1'b1;

    step("h_entry", 3'b001, 0, 0, 0, mk(3'b001, 0, 0, 0, 1, 0));
    step("h_der1",  3'b001, 0, 0, 1, mk(3'b010, 0, 0, 1, 1, 0));
    step("h_der2",  3'b001, 0, 0, 1, mk(3'b100, 0, 0, 2, 1, 0));
    step("h_wrap",  3'b001, 0, 0, 1, mk(3'b001, 0, 0, 0, 1, 0));
    step("h_izqw",  3'b001, 0, 1, 0, mk(3'b100, 0, 0, 2, 1, 0));
    step("h_flag",  3'b001, 1, 0, 0, mk(3'b100, 0, 3'b111, 2, 1, 0));
    step("t_entry", 3'b100, 1, 0, 0, mk(0, 0, 3'b001, 0, 1, 0));
    step("t_der",   3'b100, 1, 0, 1, mk(0, 0, 3'b010, 1, 1, 0));
    step("f_entry", 3'b010, 0, 0, 0, mk(0, 4'b0001, 0, 0, 1, 0));
    step("f_izqw",  3'b010, 0, 1, 0, mk(0, 4'b1000, 0, 3, 1, 0));
    step("f_both",  3'b010, 0, 1, 1, mk(0, 4'b1000, 0, 3, 1, 0));
    step("f_izq",   3'b010, 0, 1, 0, mk(0, 4'b0100, 0, 2, 1, 0));

    #1;
    rst_n = 1'b0;
    #1;
    sb.push_back(mk(0, 0, 0, 0, 0, 0));
    compare("rst_mid");
    #1;
    rst_n = 1'b1;
    step("post_rst", 3'b000, 0, 0, 0, mk(0, 0, 0, 0, 0, 0));

    step("i_entry", 3'b001, 0, 0, 0, mk(3'b001, 0, 0, 0, 1, 0));
    step("i_exit",  3'b011, 0, 0, 0, mk(0, 0, 0, 0, 0, 1));
    step("i_hold",  3'b011, 0, 0, 0, mk(0, 0, 0, 0, 0, 0));
    step("to_idle", 3'b000, 0, 0, 0, mk(0, 0, 0, 0, 0, 0));

    for (int k = 1; k <= 8; k++)
      step($sformatf("to_ed%0d", k), 3'b001, 0, 0, 0,
           mk(3'b001, 0, 0, 0, 1, 0));
    step("to_fin", 3'b001, 0, 0, 0, mk(0, 0, 0, 0, 0, 1));
    step("to_nore1", 3'b001, 0, 0, 0, mk(0, 0, 0, 0, 0, 0));
    step("to_nore2", 3'b001, 0, 0, 0, mk(0, 0, 0, 0, 0, 0));
    step("to_zero",  3'b000, 0, 0, 0, mk(0, 0, 0, 0, 0, 0));
    step("to_reent", 3'b001, 0, 0, 0, mk(3'b001, 0, 0, 0, 1, 0));

    for (int k = 1; k <= 6; k++)
      step($sformatf("clr_a%0d", k), 3'b001, 0, 0, 0,
           mk(3'b001, 0, 0, 0, 1, 0));
    step("clr_der", 3'b001, 0, 0, 1, mk(3'b010, 0, 0, 1, 1, 0));
    for (int k = 1; k <= 7; k++)
      step($sformatf("clr_b%0d", k), 3'b001, 0, 0, 0,
           mk(3'b010, 0, 0, 1, 1, 0));
    step("clr_fin", 3'b001, 0, 0, 0, mk(0, 0, 0, 0, 0, 1));

    step("idle_flag", 3'b000, 1, 0, 0, mk(0, 0, 3'b111, 0, 0, 0));
    step("m_entry",   3'b001, 0, 0, 0, mk(3'b001, 0, 0, 0, 1, 0));
    step("m_der",     3'b001, 0, 0, 1, mk(3'b010, 0, 0, 1, 1, 0));
    step("m_chg_btn", 3'b010, 0, 0, 1, mk(0, 4'b0001, 0, 0, 1, 0));
    step("m_exit_btn", 3'b000, 0, 0, 1, mk(0, 0, 0, 0, 0, 1));
    step("idle_btn",  3'b000, 0, 0, 1, mk(0, 0, 0, 0, 0, 0));
    step("idle_izq",  3'b000, 0, 1, 0, mk(0, 0, 0, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
